ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Runs on the 25 MHz clock alongside the keyboard receiver and shares the same ps2clk/ps2data lines. It drives the lines open-collector: output-enable means pull low.
- Performs the request-to-send sequence, serialises 8 data bits, odd parity and stop bit, then checks the device's line-ack.

Parameters:
- INHIBIT_CYCLES, 2500: clock-low inhibit time in clk cycles (100 us at 25 MHz).
- TIMEOUT_CYCLES, 50000: maximum clk cycles between device clock falling edges (2 ms).
- CNT_W, 16: width of the shared inhibit/timeout counter. Must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock (the 25 MHz domain).
- reset  in  1  asynchronous, active-low reset.
- ps2clk  in  1  raw PS/2 clock line level, asynchronous.
- ps2data  in  1  raw PS/2 data line level, asynchronous.
- tx_data  in  8  byte to send; sampled on accepted tx_start.
- tx_start  in  1  one-cycle request.
- ps2clk_oe  out  1  1 = pull PS/2 clock low.
- ps2data_oe  out  1  1 = pull PS/2 data low.
- busy  out  1  high from accepted start until done/timeout.
- done  out  1  one-cycle pulse when the transaction finishes.
- ack_err  out  1  valid with done: 1 = device did not acknowledge (ack bit sampled high).
- timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (reset=0), applied asynchronously: all outputs 0, bus released, state IDLE, counters 0. Asserting reset mid-transaction releases both lines immediately.
- Input synchronisation:
  - ps2clk and ps2data each pass through 2 flip-flops.
  - Falling edge = previous synced clock 1 and current synced clock 0. Detection latency is 3 clk cycles from the pin.
- Frame register (10 bits, LSB first): d0..d7, parity = ~^tx_data (odd), stop = 1.
- ps2data_oe = ~current frame bit while in SEND.
- States:
  - IDLE: oe both 0, busy 0. tx_start=1 → latch frame, counter=0, go INHIBIT, busy=1 next cycle. tx_start while busy is ignored.
  - INHIBIT: ps2clk_oe=1, ps2data_oe=0. After INHIBIT_CYCLES cycles → REQ.
  - REQ: ps2clk_oe=1, ps2data_oe=1 (start bit 0) for exactly 1 cycle → SEND with bit index 0.
  - SEND: ps2clk_oe=0 (clock released); ps2data_oe keeps the start bit driven until the first falling edge.
    - On each falling edge: present frame bit[index], index++.
    - After the edge that presents index 9 (stop, line released) → ACK.
  - ACK: on the next (11th) falling edge sample synced ps2data into ack_err_r (0 = ack OK) → WAIT_IDLE.
  - WAIT_IDLE: wait until synced ps2clk=1 and synced ps2data=1 on the same cycle. Then done=1 for one cycle, ack_err=ack_err_r, busy=0, go IDLE.
- ack_err holds its value until the next accepted start, which clears it.
- The counter is reused: it is cleared on every falling edge in SEND/ACK and on entry to SEND.
- Simultaneous tx_start and reset: reset wins.

Optional Feature:
- Macro: PS2_TX_TIMEOUT_EN.
- Defined:
  - In SEND/ACK/WAIT_IDLE, if the counter reaches TIMEOUT_CYCLES with no falling edge (or no idle in WAIT_IDLE), then: timeout=1 one cycle, release both lines, busy=0, done stays 0, go IDLE.
- Not defined:
  - No watchdog. The timeout port is tied to 0 and the block waits indefinitely.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE);
  - command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, RSP_ACK=8'hFA;
  - default timing constants for 25 MHz.
- One natural sub-module: ps2_line_sync. It contains the 2-FF synchroniser plus falling-edge detector and is reusable by the receiver.

Test Plan:
- tx_data=8'hED, tx_start pulse, device model clocking at 12.5 kHz and acking:
  - ps2clk_oe high for exactly 2500 cycles, then data low 1 cycle before clock release;
  - device reads bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - done pulses once, ack_err=0, busy low after the bus is idle.
- tx_data=8'h00: parity bit sampled = 1. tx_data=8'h01: parity = 0. Both complete with ack_err=0.
- Device model does not drive the ack (data stays high on the 11th edge) → done with ack_err=1.
- tx_start pulsed again during SEND → ignored; the frame on the wire is unchanged and exactly one done pulse occurs.
- reset driven low mid-SEND (after bit 4) → ps2clk_oe and ps2data_oe go 0 asynchronously in the same cycle; busy=0; no done. A new request then works normally.
- With PS2_TX_TIMEOUT_EN: device stops clocking after 3 bits → timeout pulses exactly 50000 cycles after the last falling edge, lines released, done never asserted. Without the macro, timeout stays 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and 25 MHz timing defaults.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  localparam int PS2_INHIBIT_CYCLES = 2500;   // 100 us
  localparam int PS2_TIMEOUT_CYCLES = 50000;  // 2 ms
  localparam int PS2_CNT_W          = 16;
  localparam int PS2_FRAME_W        = 10;

  // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
  function automatic logic [PS2_FRAME_W-1:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data lines plus a clock falling-edge detector.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2clk,
  input  logic ps2data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;

  always_comb begin
    clk_meta_d  = ps2clk;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2data;
    data_sync_d = data_meta_q;
  end

  // Idle bus level is high, so resetting to 1 avoids a spurious edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign clk_sync  = clk_sync_q;
  assign data_sync = data_sync_q;
  assign clk_fall  = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-bit frame and line-ack check.
// Define PS2_TX_TIMEOUT_EN to enable the device-clock watchdog; otherwise timeout is tied low.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int CNT_W          = PS2_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  logic clk_sync;
  logic data_sync;
  logic clk_fall;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst_n     (reset),
    .ps2clk    (ps2clk),
    .ps2data   (ps2data),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  ps2_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic [3:0]             idx_q, idx_d;
  logic [PS2_FRAME_W-1:0] frame_q, frame_d;
  logic                   data_oe_q, data_oe_d;
  logic                   ack_err_r_q, ack_err_r_d;
  logic                   ack_err_q, ack_err_d;
  logic                   done_q, done_d;
`ifdef PS2_TX_TIMEOUT_EN
  logic                   timeout_q, timeout_d;
`endif

  // Saturates so an idle watchdog count never wraps back into range.
  assign cnt_inc = (cnt_q == CNT_W'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    data_oe_d   = data_oe_q;
    ack_err_r_d = ack_err_r_q;
    ack_err_d   = ack_err_q;
    done_d      = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    timeout_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          frame_d   = build_frame(tx_data);
          cnt_d     = '0;
          idx_d     = '0;
          data_oe_d = 1'b0;
          ack_err_d = 1'b0;
          state_d   = INHIBIT;
        end
      end
      // The REQ cycle also holds the clock low, so INHIBIT is one cycle shorter.
      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 2)) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REQ: begin
        cnt_d     = '0;
        idx_d     = '0;
        data_oe_d = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        if (clk_fall) begin
          cnt_d     = '0;
          data_oe_d = ~frame_q[idx_q];
          idx_d     = idx_q + 4'd1;
          if (idx_q == 4'd9) begin
            state_d = ACK;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ACK: begin
        if (clk_fall) begin
          cnt_d       = '0;
          ack_err_r_d = data_sync;
          state_d     = WAIT_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d    = 1'b1;
          ack_err_d = ack_err_r_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    if ((((state_q == SEND) || (state_q == ACK)) && !clk_fall) ||
        ((state_q == WAIT_IDLE) && !(clk_sync && data_sync))) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        data_oe_d = 1'b0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_q     <= '0;
      data_oe_q   <= 1'b0;
      ack_err_r_q <= 1'b0;
      ack_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      data_oe_q   <= data_oe_d;
      ack_err_r_q <= ack_err_r_d;
      ack_err_q   <= ack_err_d;
      done_q      <= done_d;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Line drives decode straight from state flops so an async reset releases the bus at once.
  assign ps2clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
  assign ps2data_oe = (state_q == REQ) || ((state_q == SEND) && data_oe_q);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus with a behavioural PS/2 device, table of commands.
module tb_ps2_host_tx;

  localparam int INH  = 2500;
  localparam int TO   = 3000;
  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2clk_oe, ps2data_oe, busy, done, ack_err, timeout;
  logic       dev_clk_low, dev_data_low;
  logic       ps2clk_bus, ps2data_bus;

  assign ps2clk_bus  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_bus = ~(ps2data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2clk     (ps2clk_bus),
    .ps2data    (ps2data_bus),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .timeout    (timeout)
  );

  always #20 clk = ~clk;

  int   n_chk = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   to_cnt = 0;
  logic ack_at_done = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         dev_ack;
    bit         poke;
    logic       exp_parity;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (done === 1'b1) begin
      done_cnt++;
      ack_at_done = ack_err;
    end
    if (timeout === 1'b1) to_cnt++;
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones;
    ones = $countones(d);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic start_and_inhibit(input logic [7:0] d, input bit do_check);
    int hi, dlo;
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    hi  = 0;
    dlo = 0;
    while (ps2clk_oe && hi < 3 * INH) begin
      hi++;
      if (ps2data_oe) dlo++;
      tick();
    end
    if (do_check) begin
      check("inhibit_len", hi, INH);
      check("req_len", dlo, 1);
      check("start_bit_held", ps2data_oe, 1'b1);
    end
  endtask

  task automatic run_txn(input logic [7:0] d, input bit dev_ack, input bit poke, input logic exp_par);
    logic [9:0] got;
    logic [9:0] exp_frame;
    int w;
    exp_frame = model_frame(d);
    done_cnt  = 0;
    start_and_inhibit(d, 1'b1);
    repeat (HALF) tick();
    check("start_on_wire", ps2data_bus, 1'b0);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      if (poke && i == 3) begin
        tx_data  = ~d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (HALF - 1) tick();
      end else begin
        repeat (HALF) tick();
      end
      got[i]      = ps2data_bus;
      dev_clk_low = 1'b0;
      repeat (HALF) tick();
    end
    check("frame", got, exp_frame);
    check("parity", got[8], exp_par);
    if (dev_ack) dev_data_low = 1'b1;
    dev_clk_low = 1'b1;
    repeat (HALF) tick();
    dev_clk_low = 1'b0;
    repeat (HALF) tick();
    dev_data_low = 1'b0;
    w = 0;
    while (done_cnt == 0 && w < 200) begin
      tick();
      w++;
    end
    repeat (5) tick();
    check("done_count", done_cnt, 1);
    check("ack_err_at_done", ack_at_done, !dev_ack);
    check("ack_err_hold", ack_err, !dev_ack);
    check("busy_end", busy, 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;

    tbl.push_back('{8'hED, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{8'h01, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{8'h3C, 1'b1, 1'b1, 1'b1});
    for (int k = 0; k < 3; k++) begin
      logic [7:0] r;
      logic [9:0] f;
      r = 8'($urandom_range(0, 255));
      f = model_frame(r);
      tbl.push_back('{r, 1'($urandom_range(0, 1)), 1'b0, f[8]});
    end

    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2clk_oe, 1'b0);
    check("rst_data_oe", ps2data_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    reset = 1'b1;
    repeat (3) tick();

    for (int k = 0; k < tbl.size(); k++) begin
      run_txn(tbl[k].data, tbl[k].dev_ack, tbl[k].poke, tbl[k].exp_parity);
      repeat (10) tick();
    end

    // Reset mid-SEND with bit 4 low so the data line is actively driven when reset hits.
    done_cnt = 0;
    start_and_inhibit(8'hA5, 1'b0);
    repeat (HALF) tick();
    for (int i = 0; i < 5; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      repeat (HALF) tick();
    end
    check("pre_reset_data_oe", ps2data_oe, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_data_oe", ps2data_oe, 1'b0);
    check("async_rst_clk_oe", ps2clk_oe, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) tick();
    check("no_done_after_rst", done_cnt, 0);
    run_txn(CMD_RESET_BYTE(), 1'b1, 1'b0, 1'b1);
    repeat (10) tick();

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n;
      done_cnt = 0;
      to_cnt   = 0;
      start_and_inhibit(8'h5A, 1'b0);
      repeat (HALF) tick();
      for (int i = 0; i < 2; i++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) tick();
        dev_clk_low = 1'b0;
        repeat (HALF) tick();
      end
      dev_clk_low = 1'b1;
      n = 0;
      while (to_cnt == 0 && n < TO + 100) begin
        tick();
        n++;
        if (n == HALF) dev_clk_low = 1'b0;
      end
      check("timeout_latency", n, TO + 3);
      check("timeout_clk_oe", ps2clk_oe, 1'b0);
      check("timeout_data_oe", ps2data_oe, 1'b0);
      check("timeout_busy", busy, 1'b0);
      repeat (5) tick();
      check("timeout_pulses", to_cnt, 1);
      check("timeout_no_done", done_cnt, 0);
    end
`else
    check("timeout_never", to_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic [7:0] CMD_RESET_BYTE();
    return 8'hFF;
  endfunction

endmodule
